// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: state encodings, default limits and sizing helper for run_monitor.
`timescale 1ns/1ps
`default_nettype none

package run_monitor_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam int DEF_MAX_CYCLES   = 100000;
    localparam int DEF_STUCK_CYCLES = 16;

    // Bits needed to hold a run length of 0 .. n-1.
    function automatic int stuck_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_monitor_sat_counter.sv
// sat_counter: W-bit event counter with synchronous clear that sticks at all-ones.
`timescale 1ns/1ps
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/run_monitor.sv
// run_monitor: end-of-run / performance monitor with sticky DONE, TIMEOUT and STUCK status.
// Branch statistics counters are built only when RUN_MON_BP_STATS_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [XLEN-1:0]  last_pc,
    input  logic [XLEN-1:0]  pc,
    input  logic             retire,
    input  logic             is_cond_br,
    input  logic             is_uncond_br,
    input  logic             bp_hit,
    output logic [1:0]       state,
    output logic             done,
    output logic             timeout,
    output logic             stuck,
    output logic [CNT_W-1:0] core_cycle,
    output logic [CNT_W-1:0] inst_retired,
    output logic [CNT_W-1:0] num_cond_br,
    output logic [CNT_W-1:0] num_uncond_br,
    output logic [CNT_W-1:0] bp_correct
);

    localparam int              SW         = stuck_width(STUCK_CYCLES);
    localparam logic [SW-1:0]   STUCK_LAST = SW'(STUCK_CYCLES - 1);
    localparam logic [63:0]     TIMEOUT_AT = 64'(MAX_CYCLES) - 64'd1;

    logic [1:0]      cur_state;
    logic [1:0]      nxt_state;
    logic [XLEN-1:0] prev_pc;
    logic [SW-1:0]   stuck_cnt;

    logic pc_same;
    logic hit_done;
    logic hit_timeout;
    logic hit_stuck;
    logic run_en;
    logic set_done;
    logic set_timeout;
    logic set_stuck;

    assign pc_same     = (pc == prev_pc);
    assign hit_done    = (pc == last_pc);
    // A saturated narrow core_cycle never matches, so TIMEOUT stays off.
    assign hit_timeout = (64'(core_cycle) == TIMEOUT_AT);
    assign hit_stuck   = (stuck_cnt == STUCK_LAST) && pc_same;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (clr) begin
            nxt_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE: nxt_state = ST_RUN;
                ST_RUN: begin
                    if (hit_done) begin
                        nxt_state = ST_DONE;
                    end else if (hit_timeout || hit_stuck) begin
                        nxt_state = ST_HALT;
                    end
                end
                default: nxt_state = cur_state;
            endcase
        end
    end

    always_comb begin
        run_en      = (cur_state == ST_RUN) && !clr;
        set_done    = run_en && hit_done;
        set_timeout = run_en && !hit_done && hit_timeout;
        set_stuck   = run_en && !hit_done && !hit_timeout && hit_stuck;
    end

    assign state = cur_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            stuck   <= 1'b0;
        end else if (clr) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            if (set_done)    done    <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
            if (set_stuck)   stuck   <= 1'b1;
        end
    end

    // prev_pc only tracks RUN cycles, so the first RUN cycle sees the cleared value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_pc   <= '0;
            stuck_cnt <= '0;
        end else if (clr) begin
            prev_pc   <= '0;
            stuck_cnt <= '0;
        end else if (run_en) begin
            prev_pc <= pc;
            if (!pc_same) begin
                stuck_cnt <= '0;
            end else if (stuck_cnt != STUCK_LAST) begin
                stuck_cnt <= stuck_cnt + SW'(1);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_core_cycle (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (run_en),
        .q    (core_cycle)
    );

    sat_counter #(.W(CNT_W)) u_inst_retired (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (run_en && retire),
        .q    (inst_retired)
    );

`ifdef RUN_MON_BP_STATS_EN
    sat_counter #(.W(CNT_W)) u_num_cond_br (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (run_en && retire && is_cond_br),
        .q    (num_cond_br)
    );

    sat_counter #(.W(CNT_W)) u_num_uncond_br (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (run_en && retire && is_uncond_br),
        .q    (num_uncond_br)
    );

    sat_counter #(.W(CNT_W)) u_bp_correct (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (run_en && retire && is_cond_br && bp_hit),
        .q    (bp_correct)
    );
`else
    logic unused_bp_inputs;
    assign unused_bp_inputs = is_cond_br ^ is_uncond_br ^ bp_hit;

    assign num_cond_br   = '0;
    assign num_uncond_br = '0;
    assign bp_correct    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table of run scenarios plus hand-written corner sequences, scoreboard-checked.
`timescale 1ns/1ps
`default_nettype none

module tb_run_monitor;
    import run_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        retire = 1'b0;
    logic        is_cond_br = 1'b0;
    logic        is_uncond_br = 1'b0;
    logic        bp_hit = 1'b0;

    logic [1:0]  state;
    logic        done, timeout, stuck;
    logic [31:0] core_cycle, inst_retired, num_cond_br, num_uncond_br, bp_correct;

    logic [1:0]  state2;
    logic        done2, timeout2, stuck2;
    logic [3:0]  core_cycle2, inst_retired2, num_cond_br2, num_uncond_br2, bp_correct2;

    run_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(50), .STUCK_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .last_pc(last_pc), .pc(pc),
        .retire(retire), .is_cond_br(is_cond_br), .is_uncond_br(is_uncond_br), .bp_hit(bp_hit),
        .state(state), .done(done), .timeout(timeout), .stuck(stuck),
        .core_cycle(core_cycle), .inst_retired(inst_retired), .num_cond_br(num_cond_br),
        .num_uncond_br(num_uncond_br), .bp_correct(bp_correct)
    );

    // Narrow counters with an unreachable MAX_CYCLES: saturation instead of timeout.
    run_monitor #(.XLEN(32), .CNT_W(4), .MAX_CYCLES(1000), .STUCK_CYCLES(4)) dut2 (
        .clk(clk), .rstn(rstn), .clr(clr), .last_pc(last_pc), .pc(pc),
        .retire(retire), .is_cond_br(is_cond_br), .is_uncond_br(is_uncond_br), .bp_hit(bp_hit),
        .state(state2), .done(done2), .timeout(timeout2), .stuck(stuck2),
        .core_cycle(core_cycle2), .inst_retired(inst_retired2), .num_cond_br(num_cond_br2),
        .num_uncond_br(num_uncond_br2), .bp_correct(bp_correct2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        d, t, s;
        logic [31:0] cc, ir, cb, ub, bc;
    } exp_t;

    typedef struct {
        string       name;
        int          ncyc;
        logic [31:0] pc0, step, last;
        logic        ret;
        logic [1:0]  st;
        logic        d, t, s;
        int          cc, ir;
    } scn_t;

    exp_t sb[$];
    scn_t tbl[7];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(string nm, logic [1:0] st, logic d, logic t, logic s,
                                int cc, int ir, int cb, int ub, int bc);
        exp_t e;
        e.name = nm; e.st = st; e.d = d; e.t = t; e.s = s;
        e.cc = 32'(cc); e.ir = 32'(ir); e.cb = 32'(cb); e.ub = 32'(ub); e.bc = 32'(bc);
        return e;
    endfunction

    function automatic scn_t mk_scn(string nm, int ncyc, logic [31:0] pc0, logic [31:0] step,
                                    logic [31:0] last, logic ret, logic [1:0] st,
                                    logic d, logic t, logic s, int cc, int ir);
        scn_t r;
        r.name = nm; r.ncyc = ncyc; r.pc0 = pc0; r.step = step; r.last = last; r.ret = ret;
        r.st = st; r.d = d; r.t = t; r.s = s; r.cc = cc; r.ir = ir;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".state"},         32'(state),   32'(e.st));
        chk({e.name, ".done"},          32'(done),    32'(e.d));
        chk({e.name, ".timeout"},       32'(timeout), 32'(e.t));
        chk({e.name, ".stuck"},         32'(stuck),   32'(e.s));
        chk({e.name, ".core_cycle"},    core_cycle,    e.cc);
        chk({e.name, ".inst_retired"},  inst_retired,  e.ir);
        chk({e.name, ".num_cond_br"},   num_cond_br,   e.cb);
        chk({e.name, ".num_uncond_br"}, num_uncond_br, e.ub);
        chk({e.name, ".bp_correct"},    bp_correct,    e.bc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        retire = 1'b0; is_cond_br = 1'b0; is_uncond_br = 1'b0; bp_hit = 1'b0;
    endtask

    // clr for one cycle -> IDLE, then one edge -> RUN with everything still zero.
    task automatic start_run(string nm);
        quiet_inputs();
        clr = 1'b1;
        sb.push_back(mk({nm, ".clr"}, ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        pop_check();
        clr = 1'b0;
        sb.push_back(mk({nm, ".enter_run"}, ST_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        pop_check();
    endtask

    task automatic run_scn(scn_t r);
        start_run(r.name);
        last_pc = r.last;
        for (int i = 0; i < r.ncyc; i++) begin
            pc = r.pc0 + 32'(i) * r.step;
            retire = r.ret;
            tick();
        end
        sb.push_back(mk({r.name, ".end"}, r.st, r.d, r.t, r.s, r.cc, r.ir, 0, 0, 0));
        pop_check();
        // Terminal states are absorbing: keep the core busy and expect nothing to move.
        for (int i = 0; i < 20; i++) begin
            pc = pc + 32'h10;
            retire = 1'b1; is_cond_br = 1'b1; is_uncond_br = 1'b1; bp_hit = 1'b1;
            tick();
        end
        sb.push_back(mk({r.name, ".hold"}, r.st, r.d, r.t, r.s, r.cc, r.ir, 0, 0, 0));
        pop_check();
        quiet_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [31:0] p;
        int          ecb, eub, ebc;

        tbl[0] = mk_scn("end_of_run",  9, 32'h0,    32'h4, 32'h20,   1'b1, ST_DONE, 1, 0, 0, 9, 9);
        tbl[1] = mk_scn("stuck_pc8",  10, 32'h8,    32'h0, 32'h40,   1'b1, ST_HALT, 0, 0, 1, 5, 5);
        tbl[2] = mk_scn("stuck_pc0",  10, 32'h0,    32'h0, 32'h40,   1'b0, ST_HALT, 0, 0, 1, 4, 0);
        tbl[3] = mk_scn("timeout",    60, 32'h100,  32'h4, 32'h40,   1'b1, ST_HALT, 0, 1, 0, 50, 50);
        tbl[4] = mk_scn("done_vs_to", 50, 32'h1000, 32'h4, 32'h10C4, 1'b1, ST_DONE, 1, 0, 0, 50, 50);
        tbl[5] = mk_scn("done_first",  3, 32'h40,   32'h4, 32'h40,   1'b1, ST_DONE, 1, 0, 0, 1, 1);
        tbl[6] = mk_scn("done_pre_to",49, 32'h1000, 32'h4, 32'h10C0, 1'b0, ST_DONE, 1, 0, 0, 49, 0);

        // Reset: held low for 60ns, IDLE for one cycle after release, then RUN.
        #30;
        sb.push_back(mk("reset.during", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
        pop_check();
        chk("dut2.reset.state", 32'(state2), 32'(ST_IDLE));
        #30;
        rstn = 1'b1;
        #1;
        sb.push_back(mk("reset.release", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
        pop_check();
        sb.push_back(mk("reset.first_edge", ST_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        pop_check();

        for (int k = 0; k < 7; k++) begin
            run_scn(tbl[k]);
        end

        // STUCK asserts exactly STUCK_CYCLES cycles after pc first repeats (RUN cycle 1).
        start_run("stuck_timing");
        last_pc = 32'h40;
        pc = 32'h8;
        retire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk("stuck_timing.step", (i == 4) ? ST_HALT : ST_RUN, 0, 0,
                            (i == 4) ? 1'b1 : 1'b0, i + 1, i + 1, 0, 0, 0));
            tick();
            pop_check();
        end

        // Branch statistics, including qualifier masking.
        start_run("branch");
        last_pc = 32'hFFFF_0000;
        p = 32'h200;
        for (int i = 0; i < 10; i++) begin
            pc = p; p = p + 32'h4;
            retire = 1'b1; is_cond_br = 1'b1; is_uncond_br = 1'b0; bp_hit = (i < 7);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            pc = p; p = p + 32'h4;
            retire = 1'b1; is_cond_br = 1'b0; is_uncond_br = 1'b1; bp_hit = 1'b0;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pc = p; p = p + 32'h4;
            retire = 1'b0; is_cond_br = 1'b1; is_uncond_br = 1'b1; bp_hit = 1'b1;
            tick();
        end
        pc = p; p = p + 32'h4;
        retire = 1'b1; is_cond_br = 1'b0; is_uncond_br = 1'b0; bp_hit = 1'b1;
        tick();
        quiet_inputs();
        pc = p;
        last_pc = p;
`ifdef RUN_MON_BP_STATS_EN
        ecb = 10; eub = 3; ebc = 7;
`else
        ecb = 0; eub = 0; ebc = 0;
`endif
        sb.push_back(mk("branch.end", ST_DONE, 1, 0, 0, 17, 14, ecb, eub, ebc));
        tick();
        pop_check();

        // Saturation: dut2 has 4-bit counters and never reaches its MAX_CYCLES.
        start_run("saturate");
        last_pc = 32'h40;
        for (int i = 0; i < 30; i++) begin
            pc = 32'h300 + 32'(i) * 32'h4;
            retire = 1'b1;
            tick();
        end
        sb.push_back(mk("saturate.wide", ST_RUN, 0, 0, 0, 30, 30, 0, 0, 0));
        pop_check();
        chk("saturate.dut2.state",        32'(state2),        32'(ST_RUN));
        chk("saturate.dut2.timeout",      32'(timeout2),      32'h0);
        chk("saturate.dut2.core_cycle",   32'(core_cycle2),   32'hF);
        chk("saturate.dut2.inst_retired", 32'(inst_retired2), 32'hF);

        // Asynchronous reset mid-RUN clears without waiting for an edge.
        rstn = 1'b0;
        #2;
        sb.push_back(mk("async_reset.assert", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
        pop_check();
        chk("async_reset.dut2.core_cycle", 32'(core_cycle2), 32'h0);
        quiet_inputs();
        rstn = 1'b1;
        sb.push_back(mk("async_reset.release", ST_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
